// File: rtl/mem_io_responder.sv
// Far end of the CPU byte bus: 128KB byte RAM plus an I/O window with UART RX/TX FIFOs,
// a free-running cycle counter and a sticky stop flag. CYCLE_SNAPSHOT_EN: coherent counter reads.
module mem_io_responder #(
    parameter int RAM_ADDR_W    = 17,
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int TX_DEPTH_LOG2 = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_done
);

    localparam int RX_D = 1 << RX_DEPTH_LOG2;
    localparam int TX_D = 1 << TX_DEPTH_LOG2;

    typedef logic [RX_DEPTH_LOG2:0] rx_ptr_t;
    typedef logic [TX_DEPTH_LOG2:0] tx_ptr_t;

    localparam tx_ptr_t TX_LIMIT = tx_ptr_t'(TX_D - 1);

    logic [7:0]  ram_q [2**RAM_ADDR_W];
    logic [7:0]  ram_rd_q;
    logic [7:0]  rx_mem_q [RX_D];
    logic [7:0]  tx_mem_q [TX_D];
    rx_ptr_t     rx_wptr_q, rx_rptr_q;
    tx_ptr_t     tx_wptr_q, tx_rptr_q;
    tx_ptr_t     tx_count;
    logic [31:0] cnt_q;
    logic [7:0]  io_rd_q, io_rd_d;
    logic        rd_ram_q;
    logic        prog_done_q;
`ifdef CYCLE_SNAPSHOT_EN
    // byte0 is always served live, so only the upper three bytes need holding
    logic [31:8] snap_q;
`endif

    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_a[31:18];

    logic is_io, io_data, io_cnt, io_stop;
    logic cpu_rd, cpu_wr;
    logic ram_wr, ram_rd;
    logic rx_empty, rx_full, rx_push, rx_pop;
    logic tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0] tx_wdata;

    assign is_io   = (mem_a[17:16] == 2'b11);
    assign io_data = is_io && (mem_a[15:0] == 16'h0000);
    assign io_cnt  = is_io && (mem_a[15:2] == 14'h0001);
    assign io_stop = is_io && (mem_a[15:0] == 16'h0004);

    // every CPU-side effect is qualified by rdy_out
    assign cpu_rd = rdy_out && !mem_wr;
    assign cpu_wr = rdy_out && mem_wr;

    assign ram_wr = rst_in && cpu_wr && !is_io;
    assign ram_rd = rst_in && cpu_rd && !is_io;

    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[RX_DEPTH_LOG2] != rx_rptr_q[RX_DEPTH_LOG2]) &&
                      (rx_wptr_q[RX_DEPTH_LOG2-1:0] == rx_rptr_q[RX_DEPTH_LOG2-1:0]);
    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = cpu_rd && io_data && !rx_empty;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[TX_DEPTH_LOG2] != tx_rptr_q[TX_DEPTH_LOG2]) &&
                      (tx_wptr_q[TX_DEPTH_LOG2-1:0] == tx_rptr_q[TX_DEPTH_LOG2-1:0]);
    assign tx_count = tx_wptr_q - tx_rptr_q;
    assign tx_wdata = io_stop ? 8'h00 : mem_dout;
    assign tx_push  = cpu_wr && !tx_full && ((io_data && (mem_dout != 8'h00)) || io_stop);
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem_q[tx_rptr_q[TX_DEPTH_LOG2-1:0]];

    // one slot stays free so the write accepted on the edge rdy_out falls still fits
    assign rdy_out = (tx_count < TX_LIMIT);

    assign mem_din   = rd_ram_q ? ram_rd_q : io_rd_q;
    assign prog_done = prog_done_q;

    always_comb begin
        io_rd_d = 8'h00;
        if (io_data) begin
            if (!rx_empty) io_rd_d = rx_mem_q[rx_rptr_q[RX_DEPTH_LOG2-1:0]];
        end else if (io_cnt) begin
`ifdef CYCLE_SNAPSHOT_EN
            case (mem_a[1:0])
                2'd0:    io_rd_d = cnt_q[7:0];
                2'd1:    io_rd_d = snap_q[15:8];
                2'd2:    io_rd_d = snap_q[23:16];
                default: io_rd_d = snap_q[31:24];
            endcase
`else
            io_rd_d = cnt_q[{mem_a[1:0], 3'b000} +: 8];
`endif
        end
    end

    // storage arrays carry no reset so they map onto plain memories
    always_ff @(posedge clk_in) begin
        if (ram_wr) ram_q[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
        if (ram_rd) ram_rd_q <= ram_q[mem_a[RAM_ADDR_W-1:0]];
        if (rx_push) rx_mem_q[rx_wptr_q[RX_DEPTH_LOG2-1:0]] <= rx_data;
        if (tx_push) tx_mem_q[tx_wptr_q[TX_DEPTH_LOG2-1:0]] <= tx_wdata;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q       <= 32'd0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            io_rd_q     <= 8'h00;
            rd_ram_q    <= 1'b0;
            prog_done_q <= 1'b0;
`ifdef CYCLE_SNAPSHOT_EN
            snap_q      <= '0;
`endif
        end else begin
            cnt_q <= cnt_q + 32'd1;
            if (rx_push) rx_wptr_q <= rx_wptr_q + rx_ptr_t'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + rx_ptr_t'(1);
            if (tx_push) tx_wptr_q <= tx_wptr_q + tx_ptr_t'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + tx_ptr_t'(1);
            if (cpu_rd) begin
                rd_ram_q <= !is_io;
                io_rd_q  <= io_rd_d;
            end
            if (cpu_wr && io_stop) prog_done_q <= 1'b1;
`ifdef CYCLE_SNAPSHOT_EN
            if (cpu_rd && io_cnt && (mem_a[1:0] == 2'd0)) snap_q <= cnt_q[31:8];
`endif
        end
    end

endmodule
